mul_share_arb: RTL

Round-robin arbiter that shares one shift-add sequential multiplier (4×4 → 8-bit, start/done handshake) among NREQ requesters. Each requester presents operands with a level request. The arbiter grants one requester, launches the multiplier, waits for completion and returns the product with a one-cycle response pulse. It sits between the client blocks and the single multiplier instance and is the only driver of the multiplier's start and operand inputs.

---
 rtl/mul_share_arb_pkg.sv | 21 ++
 rtl/mul_share_arb_if.sv | 33 +++
 rtl/mul_share_arb_rr_pick.sv | 40 ++++
 rtl/mul_share_arb.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// rtl/mul_share_arb_pkg.sv - shared state type, defaults and index-width helper for mul_share_arb
package mul_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;
    localparam int IDXW_DEF = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CLR,
        WAIT,
        RESP
    } arb_state_t;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - requester and multiplier signal bundle for mul_share_arb
interface mul_share_arb_if
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_result;
    logic              mul_done;

    // Arbiter side.
    modport slave (
        input  req, a_in, b_in, mul_result, mul_done,
        output gnt, rsp_valid, rsp_data, busy, mul_start, mul_a, mul_b
    );

    // Client and multiplier side.
    modport master (
        output req, a_in, b_in, mul_result, mul_done,
        input  gnt, rsp_valid, rsp_data, busy, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mul_share_arb_rr_pick.sv
// rtl/mul_share_arb_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;

    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit and map it back.
    always_comb begin
        int s;
        s     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_rot = NREQ'({i_req, i_req} >> i_ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (!o_any && w_rot[i]) begin
                o_any = 1'b1;
                s     = int'(i_ptr) + i;
                if (s >= NREQ) begin
                    s = s - NREQ;
                end
            end
        end
        if (o_any) begin
            o_idx = IW'(s);
            o_gnt = {{(NREQ-1){1'b0}}, 1'b1} << s;
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one sequential multiplier; ZERO_SKIP_EN bypasses the multiplier for zero operands
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mul_share_arb_if.slave bus
);

    localparam int IW = idx_width(NREQ);

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [2*W-1:0]  r_rsp_data;
    logic            r_busy;
    logic            r_mul_start;
    logic [W-1:0]    r_mul_a;
    logic [W-1:0]    r_mul_b;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_a = bus.a_in[int'(w_idx)*W +: W];
    assign w_b = bus.b_in[int'(w_idx)*W +: W];

    // Grant, launch, wait for a fresh done, respond; every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_idx   <= w_idx;
                        r_mul_a <= w_a;
                        r_mul_b <= w_b;
                        r_busy  <= 1'b1;
`ifdef ZERO_SKIP_EN
                        if ((w_a == '0) || (w_b == '0)) begin
                            r_rsp_data  <= '0;
                            r_rsp_valid <= w_gnt;
                            r_state     <= RESP;
                        end else begin
                            r_mul_start <= 1'b1;
                            r_state     <= START;
                        end
`else
                        r_mul_start <= 1'b1;
                        r_state     <= START;
`endif
                    end
                end
                START: begin
                    r_state <= CLR;
                end
                // A done still high here is left over from the previous product.
                CLR: begin
                    if (!bus.mul_done) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        r_rsp_data  <= bus.mul_result;
                        r_rsp_valid <= r_gnt;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign bus.mul_start = r_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;

endmodule
